// File: rtl/drive_direction_sequencer.sv
// drive_direction_sequencer: heading/brake/duty to per-side H-bridge pins with reversal dead-time (SLOW_DECAY_EN: PWM off-phase brakes)
module drive_direction_sequencer #(
  parameter int NUM_MOTORS_PER_SIDE = 2,
  parameter int PWM_WIDTH = 8,
  parameter int DEADTIME_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic brake,
  input  logic [2:0] direction,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic [2*NUM_MOTORS_PER_SIDE-1:0] in_a,
  output logic [2*NUM_MOTORS_PER_SIDE-1:0] in_b,
  output logic [1:0] reversing,
  output logic pwm_sync
);
  localparam int N = NUM_MOTORS_PER_SIDE;
  localparam int CW = $clog2(DEADTIME_CYCLES + 1);
`ifdef SLOW_DECAY_EN
  localparam logic [1:0] OFF_PAT = 2'b11;
`else
  localparam logic [1:0] OFF_PAT = 2'b00;
`endif
  typedef enum logic [1:0] {S_BRAKE, S_DEAD, S_DRIVE} state_t;
  logic [PWM_WIDTH-1:0] pwm_cnt, duty_q;
  logic en_q, wrap, pwm_on;
  logic [1:0] req, nxt_a, nxt_b, nxt_rev;
  assign req[0] = (direction[2:1] == 2'b00) || (direction == 3'b111) || (direction == 3'b010);
  assign req[1] = (direction == 3'b010) || (direction == 3'b011) || (direction[2:1] == 2'b10);
  assign wrap = &pwm_cnt;
  assign pwm_on = (pwm_cnt < duty_q) || (&duty_q);
  for (genvar s = 0; s < 2; s++) begin : g_side
    state_t st_q, st_d;
    logic [CW-1:0] c_q, c_d;
    logic d_q, d_d;
    always_comb begin
      st_d = st_q;
      c_d = c_q;
      d_d = d_q;
      if (!enable || brake) st_d = S_BRAKE;
      else if (st_q == S_BRAKE) begin
        st_d = S_DEAD;
        c_d = CW'(DEADTIME_CYCLES);
      end else if (st_q == S_DEAD) begin
        if (c_q == CW'(1)) begin
          st_d = S_DRIVE;
          d_d = req[s];
        end else c_d = c_q - CW'(1);
      end else if (req[s] != d_q) begin
        st_d = S_DEAD;
        c_d = CW'(DEADTIME_CYCLES);
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= S_BRAKE;
        c_q <= '0;
        d_q <= 1'b1;
      end else begin
        st_q <= st_d;
        c_q <= c_d;
        d_q <= d_d;
      end
    end
    // pins follow the registered state, giving the one-cycle output pipeline
    assign {nxt_a[s], nxt_b[s]} = !en_q ? 2'b00 : (st_q != S_DRIVE) ? 2'b11 : pwm_on ? {d_q, ~d_q} : OFF_PAT;
    assign nxt_rev[s] = (st_q == S_DEAD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q <= '0;
      en_q <= 1'b0;
      pwm_sync <= 1'b0;
      in_a <= '0;
      in_b <= '0;
      reversing <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      duty_q <= wrap ? duty : duty_q;
      en_q <= enable;
      pwm_sync <= wrap;
      in_a <= {{N{nxt_a[1]}}, {N{nxt_a[0]}}};
      in_b <= {{N{nxt_b[1]}}, {N{nxt_b[0]}}};
      reversing <= nxt_rev;
    end
  end
endmodule
